// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, immediate formats and decode helpers
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  // True for every major opcode this pipeline knows how to execute.
  function automatic logic opc_is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate format select and sign extension
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output imm_fmt_e        o_fmt,
  output logic [XLEN-1:0] o_imm
);

  // Pick the immediate layout from the major opcode.
  always_comb begin
    o_fmt = FMT_NONE;
    case (i_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: o_fmt = FMT_I;
      OPC_STORE:                      o_fmt = FMT_S;
      OPC_BRANCH:                     o_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             o_fmt = FMT_U;
      OPC_JAL:                        o_fmt = FMT_J;
      default:                        o_fmt = FMT_NONE;
    endcase
  end

  // Reassemble the scattered immediate bits; the signed size cast does the sign extension.
  always_comb begin
    o_imm = '0;
    case (o_fmt)
      FMT_I: o_imm = XLEN'($signed(i_instr[31:20]));
      FMT_S: o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      FMT_B: o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
      FMT_U: o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      FMT_J: o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - RV32I decode/operand-fetch stage with write-back bypass and stall refresh
module operand_fetch
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  input  logic [XLEN-1:0] i_rv1,
  input  logic [XLEN-1:0] i_rv2,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_op1,
  output logic [XLEN-1:0] o_out_op2,
  output logic [XLEN-1:0] o_out_imm,
  output logic [4:0]      o_out_rd,
  output logic [6:0]      o_out_opcode,
  output logic [2:0]      o_out_funct3,
  output logic            o_out_funct7b5,
  output logic            o_out_illegal
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic              w_in_ready;
  logic              w_load;
  logic              w_stall;

  logic [6:0]        w_opcode;
  imm_fmt_e          w_fmt;
  logic [XLEN-1:0]   w_imm_raw;
  logic              w_illegal;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_imm;
  logic [4:0]        w_hold_rs1;
  logic [4:0]        w_hold_rs2;

  logic [XLEN-1:0]   r_out_pc;
  logic [XLEN-1:0]   r_out_op1;
  logic [XLEN-1:0]   r_out_op2;
  logic [XLEN-1:0]   r_out_imm;
  logic [4:0]        r_out_rd;
  logic [6:0]        r_out_opcode;
  logic [2:0]        r_out_funct3;
  logic              r_out_funct7b5;
  logic              r_out_illegal;
  logic [4:0]        r_hold_rs1;
  logic [4:0]        r_hold_rs2;

  assign w_opcode = i_in_instr[6:0];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (i_in_instr),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm_raw)
  );

  // Field decode; U/J formats have no rs1, only OP/STORE/BRANCH read rs2.
  always_comb begin
    w_illegal = (i_in_instr[1:0] != 2'b11) || !opc_is_legal(w_opcode);
    w_rs1     = (w_fmt == FMT_U || w_fmt == FMT_J) ? 5'd0 : i_in_instr[19:15];
    w_rs2     = (w_opcode == OPC_OP || w_opcode == OPC_STORE || w_opcode == OPC_BRANCH)
                ? i_in_instr[24:20] : 5'd0;
    w_rd      = (w_opcode == OPC_STORE || w_opcode == OPC_BRANCH) ? 5'd0 : i_in_instr[11:7];
  end

  // Operand select: x0 reads zero, a same-cycle write-back wins over the regfile read.
  // Illegal instructions carry zero operands and zero held addresses so no refresh can touch them.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_rs1 != 5'd0) w_op1 = (i_wb_we && i_wb_rd == w_rs1) ? i_wb_data : i_rv1;
    if (w_rs2 != 5'd0) w_op2 = (i_wb_we && i_wb_rd == w_rs2) ? i_wb_data : i_rv2;
    w_imm      = w_illegal ? '0 : w_imm_raw;
    w_hold_rs1 = w_illegal ? 5'd0 : w_rs1;
    w_hold_rs2 = w_illegal ? 5'd0 : w_rs2;
    if (w_illegal) begin
      w_op1 = '0;
      w_op2 = '0;
    end
  end

  // Output-stage occupancy register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  // Handshake: accept when empty or when the held bundle leaves this cycle.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    w_load       = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (i_in_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        w_in_ready = i_out_ready;
        w_stall    = !i_out_ready;
        if (i_out_ready) begin
          if (i_in_valid) w_load = 1'b1;
          else            w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Output bundle: load on transfer, otherwise keep the held operands fresh while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_pc       <= '0;
      r_out_op1      <= '0;
      r_out_op2      <= '0;
      r_out_imm      <= '0;
      r_out_rd       <= '0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7b5 <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_hold_rs1     <= '0;
      r_hold_rs2     <= '0;
    end else if (w_load) begin
      r_out_pc       <= i_in_pc;
      r_out_op1      <= w_op1;
      r_out_op2      <= w_op2;
      r_out_imm      <= w_imm;
      r_out_rd       <= w_rd;
      r_out_opcode   <= w_opcode;
      r_out_funct3   <= i_in_instr[14:12];
      r_out_funct7b5 <= i_in_instr[30];
      r_out_illegal  <= w_illegal;
      r_hold_rs1     <= w_hold_rs1;
      r_hold_rs2     <= w_hold_rs2;
    end else if (w_stall && i_wb_we && i_wb_rd != 5'd0) begin
      if (i_wb_rd == r_hold_rs1) r_out_op1 <= i_wb_data;
      if (i_wb_rd == r_hold_rs2) r_out_op2 <= i_wb_data;
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_rs1          = w_rs1;
  assign o_rs2          = w_rs2;
  assign o_out_valid    = (r_state == ST_FULL);
  assign o_out_pc       = r_out_pc;
  assign o_out_op1      = r_out_op1;
  assign o_out_op2      = r_out_op2;
  assign o_out_imm      = r_out_imm;
  assign o_out_rd       = r_out_rd;
  assign o_out_opcode   = r_out_opcode;
  assign o_out_funct3   = r_out_funct3;
  assign o_out_funct7b5 = r_out_funct7b5;
  assign o_out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, wb_we, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rv1, rv2, wb_data;
  logic [4:0]  rs1, rs2, wb_rd, out_rd;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;

  operand_fetch #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_rs1(rs1), .o_rs2(rs2),
    .i_rv1(rv1), .i_rv2(rv2), .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
    .o_out_op1(out_op1), .o_out_op2(out_op2), .o_out_imm(out_imm), .o_out_rd(out_rd),
    .o_out_opcode(out_opcode), .o_out_funct3(out_funct3),
    .o_out_funct7b5(out_funct7b5), .o_out_illegal(out_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd, s1, s2;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } bundle_t;

  function automatic logic m_legal(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    return (i[1:0] == 2'b11) &&
           (o == 7'h37 || o == 7'h17 || o == 7'h6F || o == 7'h67 || o == 7'h63 || o == 7'h03 ||
            o == 7'h23 || o == 7'h13 || o == 7'h33 || o == 7'h0F || o == 7'h73);
  endfunction

  function automatic logic [4:0] m_rs1(input logic [31:0] i);
    if (i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F) return 5'd0;
    return i[19:15];
  endfunction

  function automatic logic [4:0] m_rs2(input logic [31:0] i);
    if (i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63) return i[24:20];
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [31:0] si;
    si = i;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 32'(si >>> 20);
      7'h23: return 32'((si >>> 25) <<< 5) | 32'(i[11:7]);
      7'h63: return 32'((si >>> 31) <<< 12) | (32'(i[7]) << 11) |
                    (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      7'h37, 7'h17: return i & 32'hFFFFF000;
      7'h6F: return 32'((si >>> 31) <<< 20) | (32'(i[19:12]) << 12) |
                    (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_src(input logic [4:0] a, input logic [31:0] rv,
                                        input logic we, input logic [4:0] wr,
                                        input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wr == a) return wd;
    return rv;
  endfunction

  function automatic bundle_t m_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic we, input logic [4:0] wr,
                                       input logic [31:0] wd);
    bundle_t r;
    r.pc  = pc;
    r.ill = !m_legal(i);
    r.opc = i[6:0];
    r.f3  = i[14:12];
    r.f7  = i[30];
    r.rd  = (i[6:0] == 7'h23 || i[6:0] == 7'h63) ? 5'd0 : i[11:7];
    if (r.ill) begin
      r.s1 = 5'd0; r.s2 = 5'd0; r.op1 = 32'd0; r.op2 = 32'd0; r.imm = 32'd0;
    end else begin
      r.s1  = m_rs1(i);
      r.s2  = m_rs2(i);
      r.op1 = m_src(r.s1, a, we, wr, wd);
      r.op2 = m_src(r.s2, b, we, wr, wd);
      r.imm = m_imm(i);
    end
    return r;
  endfunction

  bundle_t m;
  logic    m_valid = 1'b0;
  logic    m_zero  = 1'b0;
  logic    started = 1'b0;

  // Reference model of the output stage.
  always @(posedge clk) begin
    if (rst) begin
      m <= '0; m_valid <= 1'b0; m_zero <= 1'b1;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m <= m_decode(in_instr, in_pc, rv1, rv2, wb_we, wb_rd, wb_data);
      m_valid <= 1'b1; m_zero <= 1'b0;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_valid && wb_we && wb_rd != 5'd0) begin
      if (wb_rd == m.s1) m.op1 <= wb_data;
      if (wb_rd == m.s2) m.op2 <= wb_data;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("rs1", 32'(rs1), 32'(m_rs1(in_instr)));
      chk("rs2", 32'(rs2), 32'(m_rs2(in_instr)));
      if (m_valid || m_zero) begin
        chk("out_pc", out_pc, m.pc);
        chk("out_op1", out_op1, m.op1);
        chk("out_op2", out_op2, m.op2);
        chk("out_imm", out_imm, m.imm);
        chk("out_rd", 32'(out_rd), 32'(m.rd));
        chk("out_opcode", 32'(out_opcode), 32'(m.opc));
        chk("out_funct3", 32'(out_funct3), 32'(m.f3));
        chk("out_funct7b5", 32'(out_funct7b5), 32'(m.f7));
        chk("out_illegal", 32'(out_illegal), 32'(m.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_instr = i; in_pc = pc; rv1 = a; rv2 = b;
  endtask

  logic [31:0] vec [12] = '{32'h123453B7, 32'hFFFFF417, 32'hFF9FF0EF, 32'h004280E7,
                            32'hFE208EE3, 32'hFFF1A303, 32'h0020A423, 32'h00000073,
                            32'h0FF0000F, 32'h40628233, 32'h12345678, 32'h0000007F};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; rv1 = '0; rv2 = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    tick(); tick();
    started = 1'b1;
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_op1", out_op1, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // ADDI x5,x1,-4
    offer(32'hFFC08293, 32'h100, 32'h10, 32'h0);
    #1 chk("addi rs1", 32'(rs1), 32'd1);
    tick();
    chk("addi valid", 32'(out_valid), 32'd1);
    chk("addi op1", out_op1, 32'h10);
    chk("addi imm", out_imm, 32'hFFFFFFFC);
    chk("addi rd", 32'(out_rd), 32'd5);
    chk("addi funct3", 32'(out_funct3), 32'd0);

    // capture-time bypass
    offer(32'h002081B3, 32'h104, 32'h10, 32'h20);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    tick();
    chk("bypass op1", out_op1, 32'hDEADBEEF);
    chk("bypass op2", out_op2, 32'h20);

    // x0 never bypasses
    offer(32'h000001B3, 32'h108, 32'h1234, 32'h1234);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    chk("x0 op1", out_op1, 32'd0);
    chk("x0 op2", out_op2, 32'd0);

    // stall with refresh
    wb_we = 1'b0;
    offer(32'h002081B3, 32'h10C, 32'h10, 32'h20);
    tick();
    out_ready = 1'b0;
    offer(32'hFFC08293, 32'h110, 32'h10, 32'h0);
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
    #1 chk("stall in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("refresh op2", out_op2, 32'h55);
    chk("refresh op1", out_op1, 32'h10);
    wb_rd = 5'd0; wb_data = 32'h99;
    tick();
    chk("x0 no refresh", out_op2, 32'h55);
    wb_we = 1'b0;
    tick();
    chk("stall held pc", out_pc, 32'h10C);
    out_ready = 1'b1;
    #1 chk("release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("next pc", out_pc, 32'h110);
    chk("next imm", out_imm, 32'hFFFFFFFC);

    // illegal instruction
    offer(32'h00000000, 32'h200, 32'h77, 32'h88);
    tick();
    chk("illegal flag", 32'(out_illegal), 32'd1);
    chk("illegal valid", 32'(out_valid), 32'd1);
    chk("illegal imm", out_imm, 32'd0);
    offer(32'hFFC08293, 32'h204, 32'h10, 32'h0);
    tick();
    chk("legal after illegal", 32'(out_illegal), 32'd0);

    // reset mid-stall
    offer(32'h002081B3, 32'h300, 32'h10, 32'h20);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst pc", out_pc, 32'd0);
    chk("rst op2", out_op2, 32'd0);
    chk("rst rd", 32'(out_rd), 32'd0);
    chk("rst opcode", 32'(out_opcode), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // pinned decodes
    offer(32'hFE208EE3, 32'h400, 32'h1, 32'h2);
    tick();
    chk("beq imm", out_imm, 32'hFFFFFFFC);
    chk("beq rd", 32'(out_rd), 32'd0);
    offer(32'hFF9FF0EF, 32'h404, 32'h5, 32'h6);
    #1 chk("jal rs1", 32'(rs1), 32'd0);
    tick();
    chk("jal imm", out_imm, 32'hFFFFFFF8);
    offer(32'h0020A423, 32'h408, 32'h7, 32'h9);
    tick();
    chk("sw imm", out_imm, 32'd8);
    chk("sw op2", out_op2, 32'h9);

    // vector sweep with periodic stalls and write-back traffic
    for (int k = 0; k < 12; k++) begin
      offer(vec[k], 32'h1000 + 32'(k * 4), 32'hA000 + 32'(k), 32'hB000 + 32'(k));
      wb_we = (k % 2) == 0; wb_rd = 5'(k % 7); wb_data = 32'hC000 + 32'(k);
      if (k % 3 == 2) begin
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; wb_we = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage sitting directly upstream of `regfile`. It accepts one 32-bit RV32I instruction per handshake, drives the regfile read addresses `rs1`/`rs2`, and samples `rv1`/`rv2`. It also decodes `rd`, the immediate and the control fields, then registers everything into a single output stage for execute. The regfile write-back port (`indata`/`rd`/`we`) is snooped so that operands are never stale, both at capture time and while the output is stalled.

## Interface
- `XLEN`, default 32: data and instruction width.
- `clk`  in  1  rising-edge clock; the same clock as `regfile`.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  XLEN  instruction word.
- `in_pc`  in  XLEN  PC of the instruction.
- `rs1`, `rs2`  out  5  regfile read addresses; combinational from `in_instr`.
- `rv1`, `rv2`  in  XLEN  regfile read data; combinational, valid in the same cycle.
- `wb_we`, `wb_rd[4:0]`, `wb_data[XLEN-1:0]`  in  snoop of the regfile `we`/`rd`/`indata`.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute accepts.
- `out_pc`, `out_op1`, `out_op2`, `out_imm`  out  XLEN  each.
- `out_rd`  out  5.
- `out_opcode`  out  7.
- `out_funct3`  out  3.
- `out_funct7b5`  out  1.
- `out_illegal`  out  1.

## Operation
- Field decode:
  - `rs1` = instr[19:15]; `rs2` = instr[24:20].
  - `rs1` is forced to 0 for LUI/AUIPC/JAL.
  - `rs2` is forced to 0 for every opcode except OP, STORE and BRANCH.
  - `out_rd` = instr[11:7], forced to 0 for STORE and BRANCH.
- Immediate generation, by opcode:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - OP: 0.
  - All formats are sign-extended to XLEN.
- Operand select, per source, in priority order:
  - address 0 gives 0;
  - else `wb_we && wb_rd == addr` gives `wb_data` (bypass);
  - else `rvN`.
- Illegal instruction:
  - Condition: instr[1:0] != 2'b11, or opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - An illegal instruction is still passed downstream with `out_illegal`=1, and op1, op2 and imm all 0.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - A transfer occurs when `in_valid && in_ready`.
  - The output register loads on transfer.
  - `out_valid` clears when `out_valid && out_ready && !in_valid`.
- Hold refresh:
  - While `out_valid && !out_ready`, a write-back with `wb_we && wb_rd != 0 && wb_rd == held rs1` replaces `out_op1` with `wb_data`. `rs2`/`out_op2` behaves the same way.
  - The held source addresses are kept in internal registers for this purpose.
- States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY to FULL on transfer.
  - FULL to FULL on a simultaneous transfer, or on a stall.
  - FULL to EMPTY when the output is consumed with no new input.

## Timing
- Latency: one cycle from the in-transfer edge to `out_valid`. Throughput is one instruction per cycle when `out_ready`=1.
- Reset (synchronous): on the next edge all `out_*` registers and the held source addresses are cleared to 0.
- `rst` has priority over any transfer in the same cycle. Reset mid-stall discards the held bundle.
- Simultaneous consume and accept in FULL:
  - The new bundle replaces the old one.
  - Hold refresh does not apply, because the bypass has already covered the new capture.
- A write-back to x0 never bypasses and never refreshes.
- `in_ready` is combinational from `out_valid`/`out_ready` only. It never depends on `in_valid`.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants (`OPC_LUI`, `OPC_OP`, …);
  - the immediate-format enum (I/S/B/U/J/NONE);
  - `XLEN`.
- Sub-module `imm_gen`: combinational; instruction in, format + sign-extended immediate out.
- Top-level: decode, the bypass/refresh muxes, and the output register.

## Test plan
- **ADDI x5,x1,-4** (0xFFC08293), `rv1`=0x10, `out_ready`=1:
  - `rs1`=1 in the same cycle;
  - next cycle `out_valid`=1, `out_op1`=0x10, `out_imm`=0xFFFFFFFC, `out_rd`=5, `out_funct3`=0.
- **Capture-time bypass, ADD x3,x1,x2** (0x002081B3), `rv1`=0x10, `rv2`=0x20, with `wb_we`=1, `wb_rd`=1, `wb_data`=0xDEADBEEF in the same cycle:
  - `out_op1`=0xDEADBEEF, `out_op2`=0x20.
- **x0 handling, ADD x3,x0,x0** (0x000001B3), `rv1`=`rv2`=0x1234, `wb_we`=1, `wb_rd`=0, `wb_data`=0xFFFF:
  - `out_op1`=`out_op2`=0.
- **Stall with refresh**: hold `out_ready`=0 for 3 cycles after accepting ADD x3,x1,x2.
  - `in_ready`=0 throughout.
  - A write-back of 0x55 to x2 during the stall sets `out_op2`=0x55, and `out_op1` is unchanged.
  - Raising `out_ready` with `in_valid`=1 accepts the next instruction in that same cycle.
- **Illegal instruction**: `in_instr`=0x00000000 gives `out_valid`=1 and `out_illegal`=1, with op1, op2 and imm all 0.
  - A following 0xFFC08293 decodes with `out_illegal`=0.
- **Reset mid-stall**: with `out_valid`=1 and `out_ready`=0, assert `rst` for 1 cycle.
  - Next edge: `out_valid`=0 and all `out_*`=0.
  - `in_ready`=1 once `out_valid` has cleared.
